// File: rtl/vrased_reset_seq.sv
// Violation-to-PUC sequencer for the VRASED monitor: stretches any sub-monitor
// violation into a held reset request and records cause, PC and episode count.
module vrased_reset_seq #(
  parameter int unsigned NUM_SRC     = 6,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter logic [15:0] WAIT_MAX    = 16'd1024,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] viol_vec,
  input  logic [15:0]        pc,
  input  logic               cause_clr,
  output logic               puc_req,
  output logic [NUM_SRC-1:0] cause,
  output logic [15:0]        viol_pc,
  output logic [CNT_W-1:0]   viol_cnt,
  output logic               stuck,
  output logic               busy
);

  localparam int unsigned HOLD_EFF  = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
  localparam int unsigned HOLD_W    = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;
  localparam int unsigned WAIT_W    = 16;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e              state_q,    state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                puc_q,      puc_d;
  logic [NUM_SRC-1:0]  cause_q,    cause_d;
  logic [15:0]         viol_pc_q,  viol_pc_d;
  logic [CNT_W-1:0]    viol_cnt_q, viol_cnt_d;
  logic                stuck_q,    stuck_d;

  logic                viol_any;
  logic [WAIT_W-1:0]   wait_next;

  assign viol_any = |viol_vec;

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      wait_cnt_q <= '0;
      puc_q      <= 1'b0;
      cause_q    <= '0;
      viol_pc_q  <= '0;
      viol_cnt_q <= '0;
      stuck_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      puc_q      <= puc_d;
      cause_q    <= cause_d;
      viol_pc_q  <= viol_pc_d;
      viol_cnt_q <= viol_cnt_d;
      stuck_q    <= stuck_d;
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    wait_cnt_d = wait_cnt_q;
    cause_d    = cause_q;
    viol_pc_d  = viol_pc_q;
    viol_cnt_d = viol_cnt_q;
    stuck_d    = stuck_q;
    wait_next  = (wait_cnt_q >= WAIT_MAX) ? WAIT_MAX : wait_cnt_q + WAIT_W'(1);

    case (state_q)
      ST_IDLE: begin
        // Clear lands first so a same-edge violation starts a fresh record
        if (cause_clr) begin
          cause_d    = '0;
          viol_cnt_d = '0;
        end
        if (viol_any) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_LOAD;
          viol_pc_d  = pc;
          cause_d    = cause_d | viol_vec;
          viol_cnt_d = (viol_cnt_d == CNT_MAX) ? viol_cnt_d : viol_cnt_d + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        cause_d = cause_q | viol_vec;
        if (hold_cnt_q == '0) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      ST_WAIT: begin
        cause_d = cause_q | viol_vec;
        if (!viol_any) begin
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_next;
          if (wait_next == WAIT_MAX) begin
            stuck_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request follows the next state so it is high in every non-idle cycle
  assign puc_d = (state_d != ST_IDLE);

  assign puc_req  = puc_q;
  assign cause    = cause_q;
  assign viol_pc  = viol_pc_q;
  assign viol_cnt = viol_cnt_q;
  assign stuck    = stuck_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vrased_reset_seq.sv
// Directed and randomized checks of vrased_reset_seq against an episode-level model.
module tb_vrased_reset_seq;

  localparam int unsigned NSRC    = 6;
  localparam int unsigned HOLD    = 8;
  localparam int unsigned WMAX    = 16;
  localparam int unsigned CW      = 2;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NSRC-1:0] viol_vec;
  logic [15:0]     pc;
  logic            cause_clr;
  logic            puc_req;
  logic [NSRC-1:0] cause;
  logic [15:0]     viol_pc;
  logic [CW-1:0]   viol_cnt;
  logic            stuck;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  // Episode model: active flag, cycles into the episode, cycles waited with violation
  bit              m_active;
  int              m_age;
  int              m_waited;
  logic [NSRC-1:0] m_cause;
  logic [15:0]     m_pc;
  int              m_cnt;
  bit              m_stuck;

  vrased_reset_seq #(
    .NUM_SRC    (NSRC),
    .HOLD_CYCLES(HOLD),
    .WAIT_MAX   (16'(WMAX)),
    .CNT_W      (CW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .viol_vec (viol_vec),
    .pc       (pc),
    .cause_clr(cause_clr),
    .puc_req  (puc_req),
    .cause    (cause),
    .viol_pc  (viol_pc),
    .viol_cnt (viol_cnt),
    .stuck    (stuck),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_age    = 0;
    m_waited = 0;
    m_cause  = '0;
    m_pc     = '0;
    m_cnt    = 0;
    m_stuck  = 1'b0;
  endtask

  task automatic model_step(input logic [NSRC-1:0] v, input logic [15:0] p, input logic c);
    if (!m_active) begin
      if (c) begin
        m_cause = '0;
        m_cnt   = 0;
      end
      if (v != '0) begin
        m_active = 1'b1;
        m_age    = 0;
        m_pc     = p;
        m_cause  = m_cause | v;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end else begin
      m_cause = m_cause | v;
      if (m_age < int'(HOLD)) begin
        m_age++;
        m_waited = 0;
      end else if (v == '0) begin
        m_active = 1'b0;
      end else begin
        if (m_waited < int'(WMAX)) m_waited++;
        if (m_waited == int'(WMAX)) m_stuck = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".puc_req"},  32'(puc_req),  32'(m_active));
    chk({tag, ".busy"},     32'(busy),     32'(m_active));
    chk({tag, ".cause"},    32'(cause),    32'(m_cause));
    chk({tag, ".viol_pc"},  32'(viol_pc),  32'(m_pc));
    chk({tag, ".viol_cnt"}, 32'(viol_cnt), 32'(m_cnt));
    chk({tag, ".stuck"},    32'(stuck),    32'(m_stuck));
  endtask

  task automatic step(input logic [NSRC-1:0] v, input logic [15:0] p, input logic c, input string tag);
    viol_vec  = v;
    pc        = p;
    cause_clr = c;
    @(posedge clk);
    model_step(v, p, c);
    #1;
    check_model(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    reset_n   = 1'b0;
    viol_vec  = '0;
    pc        = '0;
    cause_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step('0, 16'h0000, 1'b0, "idle");

    // Single-cycle pulse
    step(6'b000010, 16'hA010, 1'b0, "pulse");
    chk("pulse.latency", 32'(puc_req), 32'd1);
    hi = 1;
    for (int i = 0; i < 12; i++) begin
      step('0, 16'h1234, 1'b0, "pulse_tail");
      if (puc_req) hi++;
    end
    chk("pulse.width", 32'(hi), 32'd9);
    chk("pulse.cause", 32'(cause), 32'h02);
    chk("pulse.viol_pc", 32'(viol_pc), 32'hA010);
    chk("pulse.viol_cnt", 32'(viol_cnt), 32'd1);

    // Persisting violation with mid-episode extra source
    step('0, 16'h0000, 1'b1, "clr");
    chk("clr.cause", 32'(cause), 32'h00);
    step(6'b000001, 16'hB000, 1'b0, "persist");
    for (int i = 1; i < 20; i++)
      step((i >= 10) ? 6'b010001 : 6'b000001, 16'hB000 + 16'(i), 1'b0, "persist");
    chk("persist.held", 32'(puc_req), 32'd1);
    step('0, 16'h0000, 1'b0, "persist_drop");
    chk("persist.dropped", 32'(puc_req), 32'd0);
    chk("persist.cause", 32'(cause), 32'h11);
    chk("persist.viol_pc", 32'(viol_pc), 32'hB000);
    chk("persist.viol_cnt", 32'(viol_cnt), 32'd1);

    // New episode in the first idle cycle: one-cycle gap
    step(6'b000001, 16'hC000, 1'b0, "gap");
    chk("gap.restart", 32'(puc_req), 32'd1);
    chk("gap.viol_cnt", 32'(viol_cnt), 32'd2);
    repeat (12) step('0, 16'h0000, 1'b0, "gap_tail");

    // Saturation over five episodes
    step('0, 16'h0000, 1'b1, "clr");
    for (int e = 0; e < 5; e++) begin
      step(6'b100000, 16'hD000 + 16'(e), 1'b0, "sat");
      chk($sformatf("sat.cnt%0d", e), 32'(viol_cnt), (e < 3) ? 32'(e + 1) : 32'd3);
      repeat (10) step('0, 16'h0000, 1'b0, "sat_tail");
    end
    chk("sat.cause", 32'(cause), 32'h20);

    // Clear and violation on the same idle edge
    step(6'b001000, 16'hE000, 1'b1, "collide");
    chk("collide.cause", 32'(cause), 32'h08);
    chk("collide.viol_cnt", 32'(viol_cnt), 32'd1);
    repeat (10) step('0, 16'h0000, 1'b0, "collide_tail");

    // Stuck violation
    step('0, 16'h0000, 1'b1, "clr");
    hi = 0;
    step(6'b000100, 16'hF000, 1'b0, "stuck");
    for (int i = 0; i < 40; i++) begin
      if (stuck) break;
      if (puc_req) hi++;
      step(6'b000100, 16'hF000, 1'b0, "stuck");
    end
    chk("stuck.raised", 32'(stuck), 32'd1);
    chk("stuck.puc_cycles", 32'(hi), 32'd24);
    step(6'b000100, 16'hF000, 1'b1, "stuck_clr");
    chk("stuck.clr_ignored", 32'(cause), 32'h04);
    repeat (3) step(6'b000100, 16'hF000, 1'b0, "stuck_hold");
    chk("stuck.puc_held", 32'(puc_req), 32'd1);
    repeat (2) step('0, 16'h0000, 1'b0, "stuck_release");
    step('0, 16'h0000, 1'b1, "stuck_idle_clr");
    chk("stuck.sticky", 32'(stuck), 32'd1);

    // Asynchronous reset in HOLD
    step(6'b000010, 16'h5555, 1'b0, "arst");
    repeat (2) step(6'b000010, 16'h5556, 1'b0, "arst");
    chk("arst.busy_before", 32'(busy), 32'd1);
    #2;
    reset_n  = 1'b0;
    viol_vec = '0;
    #1;
    model_reset();
    check_model("arst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) step('0, 16'h0000, 1'b0, "arst_idle");
    chk("arst.idle", 32'(busy), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [NSRC-1:0] v;
      int r;
      r = int'($urandom_range(0, 99));
      v = (r < 20) ? NSRC'($urandom) : '0;
      step(v, 16'($urandom), 1'($urandom_range(0, 9) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
